fir_da_sched: RTL and testbench
===============================

Name: fir_da_sched

Overview:
- Time-shares one bit-serial distributed-arithmetic FIR engine (13-cycle processing per sample) between N_CH independent sample channels.
- Arbitrates channel requests round-robin and issues one sample at a time to the engine with a channel context tag.
- Collects the engine result and returns it on a tagged valid/ready output.
- Adds a per-sample watchdog so a hung engine cannot stall the shared path.

Parameters:
N_CH, 4, number of requesting channels (2..8)
CH_W, 2, channel index width, clog2(N_CH)
IDATA_WIDTH, 12, input sample width (two's complement)
ODATA_WIDTH, 27, filter result width (two's complement)
TIMEOUT, 32, max cycles in WAIT before abort (must be > engine latency of 14)

Ports:
sys_clk  in  1  clock
sys_rstn  in  1  reset; asynchronous, active-low
ch_en  in  N_CH  per-channel enable; disabled channels are never granted
ch_vld  in  N_CH  per-channel sample valid
ch_dat  in  N_CH*IDATA_WIDTH  packed samples, channel i at [i*IDATA_WIDTH +: IDATA_WIDTH]
ch_rdy  out  N_CH  one-hot accept strobe
eng_start  out  1  one-cycle start pulse to engine
eng_din  out  IDATA_WIDTH  sample to engine, held stable from eng_start until done/abort
eng_ctx  out  CH_W  channel context select for engine delay line
eng_abort  out  1  one-cycle abort pulse on timeout
eng_done  in  1  engine result strobe
eng_dout  in  ODATA_WIDTH  engine result, valid with eng_done
out_vld  out  1  result valid
out_rdy  in  1  downstream ready
out_dat  out  ODATA_WIDTH  filtered result
out_ch  out  CH_W  channel tag of out_dat
busy  out  1  high whenever state != IDLE
err_clr  in  1  clears sticky error
err_timeout  out  1  sticky watchdog error
err_ch  out  CH_W  channel of most recent timeout

Behaviour:
- Reset (async, any state, mid-operation): state=IDLE, rr_ptr=0, timer=0; all outputs 0 (ch_rdy, eng_*, out_*, busy, err_*). An in-flight sample is discarded; no eng_abort is issued by reset.
- States: IDLE, ISSUE, WAIT, OUT.
- Eligibility: elig[i] = ch_vld[i] & ch_en[i].
- IDLE grant: g is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
- IDLE handshake: ch_rdy[g]=1 combinationally in the same cycle; the transfer completes that cycle.
  - Latch ch_dat[g] into eng_din and g into eng_ctx.
  - rr_ptr <= (g+1) mod N_CH; go to ISSUE.
  - No eligible request: stay IDLE with ch_rdy=0.
- ch_rdy is 0 in every state except IDLE. At most one bit is ever set.
- ISSUE: eng_start=1 for exactly one cycle, timer<=0, go to WAIT.
- WAIT: timer increments each cycle.
  - eng_done=1: out_dat<=eng_dout, out_ch<=eng_ctx, out_vld<=1, go to OUT. Done takes priority over timeout in the same cycle.
  - Else if timer==TIMEOUT-1: eng_abort=1 for one cycle, err_timeout<=1, err_ch<=eng_ctx, sample dropped, go to IDLE.
- OUT: out_vld held with out_dat/out_ch stable until out_rdy=1. That cycle out_vld<=0 and go to IDLE. A new grant is possible in the following cycle.
- eng_done outside WAIT is ignored.
- Latency, with accept at cycle 0:
  - eng_start at cycle 1.
  - If the engine asserts done at cycle 1+L, out_vld rises at cycle 2+L.
  - Nominal L=14 gives out_vld at cycle 16.
  - Minimum per-sample occupancy is L+3 cycles when out_rdy is held high.
- err_clr clears err_timeout; err_ch keeps its value. If err_clr and a new timeout occur in the same cycle, set wins.
- A ch_en deassert while that channel's sample is in flight does not cancel the sample.
- Widths: the block does no arithmetic on data; eng_dout passes through unmodified. Timer width is clog2(TIMEOUT)+1 and never wraps.

Test Plan:
- Single channel: ch_en=4'b0001, ch_vld[0] with 12'h7FF, engine model returns 27'h00123AB after 14 cycles, out_rdy=1 -> ch_rdy[0] at cycle 0, eng_start at cycle 1, out_vld at cycle 16 with out_dat=27'h00123AB, out_ch=0, busy low at cycle 17.
- Round-robin: all four channels continuously valid and enabled, rr_ptr=0 -> grant order 0,1,2,3,0; each channel granted once per 4 samples; ch_rdy always one-hot.
- Enable masking: ch_vld=4'b1111, ch_en=4'b1010 -> only channels 1 and 3 granted, alternating 1,3,1,3; ch_rdy[0] and ch_rdy[2] never asserted.
- Backpressure: out_rdy=0 for 20 cycles after out_vld -> out_vld/out_dat/out_ch stable, ch_rdy=4'b0000, no eng_start until 1 cycle after out_rdy rises.
- Watchdog: engine never asserts done, TIMEOUT=32 on channel 2 -> eng_abort pulse 32 cycles after eng_start, err_timeout=1, err_ch=2, no out_vld. err_clr in the same cycle as a second timeout leaves err_timeout=1.
- Async reset asserted during WAIT -> all outputs 0 immediately. After release, the first grant goes to the lowest eligible index (rr_ptr=0) and no stale out_vld appears.

Source files
------------

// File: rtl/fir_da_sched.sv
// Shares one bit-serial DA FIR engine between N_CH sample channels:
// round-robin grant, tagged issue, tagged result return and per-sample watchdog.
module fir_da_sched #(
   parameter int N_CH        = 4,
   parameter int CH_W        = 2,
   parameter int IDATA_WIDTH = 12,
   parameter int ODATA_WIDTH = 27,
   parameter int TIMEOUT     = 32
) (
   input  logic                        sys_clk,
   input  logic                        sys_rstn,
   input  logic [N_CH-1:0]             ch_en,
   input  logic [N_CH-1:0]             ch_vld,
   input  logic [N_CH*IDATA_WIDTH-1:0] ch_dat,
   output logic [N_CH-1:0]             ch_rdy,
   output logic                        eng_start,
   output logic [IDATA_WIDTH-1:0]      eng_din,
   output logic [CH_W-1:0]             eng_ctx,
   output logic                        eng_abort,
   input  logic                        eng_done,
   input  logic [ODATA_WIDTH-1:0]      eng_dout,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [ODATA_WIDTH-1:0]      out_dat,
   output logic [CH_W-1:0]             out_ch,
   output logic                        busy,
   input  logic                        err_clr,
   output logic                        err_timeout,
   output logic [CH_W-1:0]             err_ch
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CH_W-1:0]   rr_ptr;
   logic [TMR_W-1:0]  timer;
   logic [N_CH-1:0]   elig;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;
   logic [CH_W:0]     scan_idx;
   logic              timeout_hit;

   assign elig        = ch_vld & ch_en;
   assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
   assign busy        = (state != ST_IDLE);

   // Rotating-priority scan: first eligible channel at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_CH; k++) begin
         scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
         if (scan_idx >= (CH_W+1)'(N_CH))
            scan_idx = scan_idx - (CH_W+1)'(N_CH);
         if (!grant_vld && elig[scan_idx[CH_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // ch_rdy is gated by reset so no accept strobe leaks out while reset is held.
   always_comb begin
      state_nxt = state;
      ch_rdy    = '0;
      eng_start = 1'b0;
      eng_abort = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_vld) begin
               ch_rdy[grant_idx] = sys_rstn;
               state_nxt         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            eng_start = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               state_nxt = ST_OUT;
            end else if (timeout_hit) begin
               eng_abort = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (out_rdy)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The timer leaves WAIT at TIMEOUT-1 at the latest, so it cannot wrap.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rr_ptr      <= '0;
         timer       <= '0;
         eng_din     <= '0;
         eng_ctx     <= '0;
         out_vld     <= 1'b0;
         out_dat     <= '0;
         out_ch      <= '0;
         err_timeout <= 1'b0;
         err_ch      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  eng_din <= ch_dat[grant_idx*IDATA_WIDTH +: IDATA_WIDTH];
                  eng_ctx <= grant_idx;
                  rr_ptr  <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
               end
            end
            ST_ISSUE: timer <= '0;
            ST_WAIT: begin
               timer <= timer + 1'b1;
               if (eng_done) begin
                  out_dat <= eng_dout;
                  out_ch  <= eng_ctx;
                  out_vld <= 1'b1;
               end
            end
            ST_OUT: begin
               if (out_rdy)
                  out_vld <= 1'b0;
            end
            default: ;
         endcase

         if (eng_abort) begin
            err_timeout <= 1'b1;
            err_ch      <= eng_ctx;
         end else if (err_clr) begin
            err_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_da_sched.sv
// Directed bench for fir_da_sched with a simple latency-programmable engine model.
module tb_fir_da_sched;

   localparam int N_CH = 4;
   localparam int CH_W = 2;
   localparam int IW   = 12;
   localparam int OW   = 27;
   localparam int TO   = 32;

   logic              sys_clk  = 1'b0;
   logic              sys_rstn = 1'b0;
   logic [N_CH-1:0]   ch_en, ch_vld, ch_rdy;
   logic [N_CH*IW-1:0] ch_dat;
   logic              eng_start, eng_abort, eng_done;
   logic [IW-1:0]     eng_din;
   logic [CH_W-1:0]   eng_ctx;
   logic [OW-1:0]     eng_dout;
   logic              out_vld, out_rdy;
   logic [OW-1:0]     out_dat;
   logic [CH_W-1:0]   out_ch;
   logic              busy, err_clr, err_timeout;
   logic [CH_W-1:0]   err_ch;

   int checks = 0;
   int errors = 0;
   int eng_lat = 14;
   logic [OW-1:0] resp_base = '0;
   logic eng_active;
   int   eng_cnt;

   fir_da_sched #(
      .N_CH(N_CH), .CH_W(CH_W), .IDATA_WIDTH(IW), .ODATA_WIDTH(OW), .TIMEOUT(TO)
   ) dut (
      .sys_clk(sys_clk), .sys_rstn(sys_rstn),
      .ch_en(ch_en), .ch_vld(ch_vld), .ch_dat(ch_dat), .ch_rdy(ch_rdy),
      .eng_start(eng_start), .eng_din(eng_din), .eng_ctx(eng_ctx),
      .eng_abort(eng_abort), .eng_done(eng_done), .eng_dout(eng_dout),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_ch(out_ch),
      .busy(busy), .err_clr(err_clr), .err_timeout(err_timeout), .err_ch(err_ch)
   );

   always #5 sys_clk = ~sys_clk;

   // Engine model: done arrives eng_lat cycles after the eng_start cycle; eng_lat==0 hangs.
   always @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         eng_active <= 1'b0;
         eng_cnt    <= 0;
         eng_done   <= 1'b0;
         eng_dout   <= '0;
      end else begin
         eng_done <= 1'b0;
         if (eng_abort) begin
            eng_active <= 1'b0;
         end else if (eng_start) begin
            eng_active <= (eng_lat > 0);
            eng_cnt    <= 1;
         end else if (eng_active) begin
            if (eng_cnt == eng_lat - 1) begin
               eng_done   <= 1'b1;
               eng_dout   <= resp_base + OW'(eng_ctx);
               eng_active <= 1'b0;
            end else begin
               eng_cnt <= eng_cnt + 1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] global timeout");
   end

   task automatic step();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic do_reset();
      sys_rstn = 1'b0;
      ch_en    = '0;
      ch_vld   = '0;
      ch_dat   = '0;
      out_rdy  = 1'b0;
      err_clr  = 1'b0;
      #12;
      step();
      sys_rstn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      ch_en   = '1;
      ch_vld  = '1;
      ch_dat  = {12'h444, 12'h333, 12'h222, 12'h111};
      out_rdy = 1'b1;
      err_clr = 1'b0;
      #13;
      checks++;
      if ({ch_rdy, eng_start, eng_abort, eng_din, eng_ctx, out_vld, out_dat, out_ch,
           busy, err_timeout, err_ch} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: ch_rdy=%b start=%b busy=%b out_vld=%b err=%b, expected all 0",
                  ch_rdy, eng_start, busy, out_vld, err_timeout);
      end
      do_reset();
      checks++;
      if (busy !== 1'b0 || ch_rdy !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_idle: busy=%b ch_rdy=%b, expected 0 and 0000", busy, ch_rdy);
      end
   endtask

   task automatic test_single();
      bit bad;
      do_reset();
      resp_base = 27'h00123AB;
      eng_lat   = 14;
      out_rdy   = 1'b1;
      ch_en     = 4'b0001;
      ch_vld    = 4'b0001;
      ch_dat[IW-1:0] = 12'h7FF;
      #1;
      checks++;
      if (ch_rdy !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL single_grant: ch_rdy=%b, expected 0001", ch_rdy);
      end
      step();
      ch_vld = '0;
      #1;
      checks++;
      if (eng_start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_start: eng_start=%b busy=%b, expected 1 1", eng_start, busy);
      end
      checks++;
      if (eng_din !== 12'h7FF || eng_ctx !== 2'd0) begin
         errors++;
         $display("[TB] FAIL single_din: eng_din=%h eng_ctx=%0d, expected 7ff 0", eng_din, eng_ctx);
      end
      step();
      checks++;
      if (eng_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_start_pulse: eng_start=%b at cycle 2, expected 0", eng_start);
      end
      bad = 1'b0;
      repeat (13) begin
         step();
         if (out_vld !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_early_vld: out_vld seen before cycle 16 (%b), expected 0", bad);
      end
      step();
      checks++;
      if (out_vld !== 1'b1 || out_dat !== 27'h00123AB || out_ch !== 2'd0) begin
         errors++;
         $display("[TB] FAIL single_result: out_vld=%b out_dat=%h out_ch=%0d, expected 1 00123ab 0",
                  out_vld, out_dat, out_ch);
      end
      step();
      checks++;
      if (busy !== 1'b0 || out_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_idle: busy=%b out_vld=%b at cycle 17, expected 0 0", busy, out_vld);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int ng, nout, cyc;
      bit onehot_bad;
      logic [3:0] exp_rdy;
      do_reset();
      resp_base = 27'h0ABC000;
      eng_lat   = 4;
      out_rdy   = 1'b1;
      ch_en     = 4'b1111;
      ch_vld    = 4'b1111;
      ch_dat    = {12'h400, 12'h300, 12'h200, 12'h100};
      #1;
      ng = 0; nout = 0; cyc = 0; onehot_bad = 1'b0;
      while (nout < 5 && cyc < 300) begin
         if (ch_rdy !== 4'b0000) begin
            if (!$onehot(ch_rdy)) onehot_bad = 1'b1;
            if (ng < 5) begin
               exp_rdy = 4'b0001 << exp_order[ng];
               checks++;
               if (ch_rdy !== exp_rdy) begin
                  errors++;
                  $display("[TB] FAIL rr_grant%0d: ch_rdy=%b, expected %b", ng, ch_rdy, exp_rdy);
               end
            end
            ng++;
         end
         if (out_vld === 1'b1) begin
            checks++;
            if (out_ch !== CH_W'(exp_order[nout]) ||
                out_dat !== resp_base + OW'(exp_order[nout])) begin
               errors++;
               $display("[TB] FAIL rr_out%0d: out_ch=%0d out_dat=%h, expected %0d %h", nout,
                        out_ch, out_dat, exp_order[nout], resp_base + OW'(exp_order[nout]));
            end
            nout++;
         end
         step();
         cyc++;
      end
      checks++;
      if (nout !== 5) begin
         errors++;
         $display("[TB] FAIL rr_count: %0d results in budget, expected 5", nout);
      end
      checks++;
      if (onehot_bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rr_onehot: non-one-hot ch_rdy seen (%b), expected 0", onehot_bad);
      end
   endtask

   task automatic test_enable_mask();
      int exp_order[4] = '{1, 3, 1, 3};
      int ng, cyc;
      bit masked_bad;
      logic [3:0] exp_rdy;
      do_reset();
      resp_base = 27'h0000500;
      eng_lat   = 4;
      out_rdy   = 1'b1;
      ch_en     = 4'b1010;
      ch_vld    = 4'b1111;
      ch_dat    = {12'h004, 12'h003, 12'h002, 12'h001};
      #1;
      ng = 0; cyc = 0; masked_bad = 1'b0;
      while (ng < 4 && cyc < 200) begin
         if (ch_rdy[0] === 1'b1 || ch_rdy[2] === 1'b1) masked_bad = 1'b1;
         if (ch_rdy !== 4'b0000) begin
            exp_rdy = 4'b0001 << exp_order[ng];
            checks++;
            if (ch_rdy !== exp_rdy) begin
               errors++;
               $display("[TB] FAIL mask_grant%0d: ch_rdy=%b, expected %b", ng, ch_rdy, exp_rdy);
            end
            ng++;
         end
         step();
         cyc++;
      end
      checks++;
      if (ng !== 4 || masked_bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mask_disabled: grants=%0d masked_seen=%b, expected 4 0", ng, masked_bad);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit bad_hold, bad_rdy, bad_start;
      do_reset();
      resp_base = 27'h5555555;
      eng_lat   = 14;
      out_rdy   = 1'b0;
      ch_en     = 4'b0001;
      ch_vld    = 4'b0001;
      ch_dat[IW-1:0] = 12'h0AA;
      #1;
      cyc = 0;
      while (out_vld !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      checks++;
      if (out_vld !== 1'b1 || out_dat !== 27'h5555555 || out_ch !== 2'd0) begin
         errors++;
         $display("[TB] FAIL bp_first: out_vld=%b out_dat=%h out_ch=%0d, expected 1 5555555 0",
                  out_vld, out_dat, out_ch);
      end
      bad_hold = 1'b0; bad_rdy = 1'b0; bad_start = 1'b0;
      repeat (20) begin
         step();
         if (out_vld !== 1'b1 || out_dat !== 27'h5555555 || out_ch !== 2'd0) bad_hold = 1'b1;
         if (ch_rdy !== 4'b0000) bad_rdy = 1'b1;
         if (eng_start !== 1'b0) bad_start = 1'b1;
      end
      checks++;
      if (bad_hold !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_hold: output changed under backpressure (%b), expected 0", bad_hold);
      end
      checks++;
      if (bad_rdy !== 1'b0 || bad_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_stall: ch_rdy_seen=%b start_seen=%b, expected 0 0", bad_rdy, bad_start);
      end
      out_rdy = 1'b1;
      step();
      checks++;
      if (out_vld !== 1'b0 || ch_rdy !== 4'b0001 || eng_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_release: out_vld=%b ch_rdy=%b eng_start=%b, expected 0 0001 0",
                  out_vld, ch_rdy, eng_start);
      end
      step();
      ch_vld = '0;
      #1;
      checks++;
      if (eng_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_restart: eng_start=%b, expected 1", eng_start);
      end
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drain: busy=%b after budget, expected 0", busy);
      end
   endtask

   task automatic test_watchdog();
      int cyc;
      bit bad;
      do_reset();
      eng_lat = 0;
      out_rdy = 1'b1;
      ch_en   = 4'b0100;
      ch_vld  = 4'b0100;
      ch_dat[2*IW +: IW] = 12'h321;
      #1;
      checks++;
      if (ch_rdy !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL wd_grant: ch_rdy=%b, expected 0100", ch_rdy);
      end
      step();
      ch_vld = '0;
      #1;
      checks++;
      if (eng_start !== 1'b1 || eng_ctx !== 2'd2 || eng_din !== 12'h321) begin
         errors++;
         $display("[TB] FAIL wd_start: start=%b ctx=%0d din=%h, expected 1 2 321", eng_start, eng_ctx, eng_din);
      end
      bad = 1'b0;
      repeat (TO - 1) begin
         step();
         if (eng_abort !== 1'b0 || out_vld !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wd_early: abort/out_vld before deadline (%b), expected 0", bad);
      end
      step();
      checks++;
      if (eng_abort !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wd_abort: eng_abort=%b 32 cycles after start, expected 1", eng_abort);
      end
      step();
      checks++;
      if (eng_abort !== 1'b0 || err_timeout !== 1'b1 || err_ch !== 2'd2 || busy !== 1'b0 || out_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wd_err: abort=%b err=%b err_ch=%0d busy=%b out_vld=%b, expected 0 1 2 0 0",
                  eng_abort, err_timeout, err_ch, busy, out_vld);
      end
      ch_vld = 4'b0100;
      step();
      ch_vld = '0;
      cyc = 0;
      while (eng_abort !== 1'b1 && cyc < 60) begin
         step();
         cyc++;
      end
      checks++;
      if (eng_abort !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wd_second: eng_abort=%b within budget, expected 1", eng_abort);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #1;
      checks++;
      if (err_timeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wd_set_wins: err_timeout=%b, expected 1", err_timeout);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #1;
      checks++;
      if (err_timeout !== 1'b0 || err_ch !== 2'd2) begin
         errors++;
         $display("[TB] FAIL wd_clear: err_timeout=%b err_ch=%0d, expected 0 2", err_timeout, err_ch);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      do_reset();
      eng_lat   = 14;
      resp_base = 27'h0777000;
      out_rdy   = 1'b1;
      ch_en     = 4'b1111;
      ch_vld    = 4'b0010;
      ch_dat    = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
      #1;
      checks++;
      if (ch_rdy !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL ar_grant: ch_rdy=%b, expected 0010", ch_rdy);
      end
      step();
      ch_vld = '0;
      repeat (4) step();
      #2;
      sys_rstn = 1'b0;
      ch_vld   = 4'b1111;
      #1;
      checks++;
      if ({ch_rdy, eng_start, eng_abort, eng_din, eng_ctx, out_vld, out_dat, out_ch,
           busy, err_timeout, err_ch} !== '0) begin
         errors++;
         $display("[TB] FAIL ar_outputs: ch_rdy=%b busy=%b din=%h ctx=%0d, expected all 0",
                  ch_rdy, busy, eng_din, eng_ctx);
      end
      step();
      sys_rstn = 1'b1;
      #1;
      checks++;
      if (ch_rdy !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL ar_first_grant: ch_rdy=%b, expected 0001", ch_rdy);
      end
      step();
      ch_vld = '0;
      cyc = 1;
      while (out_vld !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      checks++;
      if (cyc !== 16 || out_ch !== 2'd0 || out_dat !== 27'h0777000) begin
         errors++;
         $display("[TB] FAIL ar_result: out_vld at cycle %0d ch=%0d dat=%h, expected 16 0 0777000",
                  cyc, out_ch, out_dat);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_enable_mask();
      test_back_to_back();
      test_watchdog();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
